// File: rtl/alu_result_streamer_if.sv
// Byte-stream bus between the ALU result streamer and its capture/sink side.
// The master modport is the streamer; the slave modport is the ALU/sink environment.
interface alu_result_streamer_if #(
    parameter int P_WIDTH = 16
);
    logic               start;
    logic [P_WIDTH-1:0] result;
    logic [4:0]         status;
    logic [7:0]         stream_byte;
    logic               valid;
    logic               ready;
    logic               busy;
    logic               done;

    modport master (
        input  start, result, status, ready,
        output stream_byte, valid, busy, done
    );

    modport slave (
        output start, result, status, ready,
        input  stream_byte, valid, busy, done
    );
endinterface

// File: rtl/alu_result_streamer.sv
// Snapshots a CR16 ALU result and status flags, then streams them as a framed,
// checksummed byte sequence (header, result MSB first, status, XOR checksum).
module alu_result_streamer #(
    parameter int         P_WIDTH  = 16,
    parameter logic [7:0] P_HEADER = 8'hA5
) (
    input logic                   clk,
    input logic                   rst_n,
    alu_result_streamer_if.master bus
);
    // P_WIDTH is expected to be a non-zero multiple of 8.
    localparam int               N        = P_WIDTH / 8;
    localparam int               IDX_W    = (N > 1) ? $clog2(N) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

    typedef enum logic [2:0] {
        IDLE,
        HEADER,
        DATA,
        STATUS,
        CHECKSUM
    } state_t;

    state_t             state, state_next;
    logic [P_WIDTH-1:0] result_q, result_next;
    logic [4:0]         status_q, status_next;
    logic [IDX_W-1:0]   index, index_next;
    logic [7:0]         checksum, checksum_next;
    logic [7:0]         byte_q, byte_next;
    logic               valid_q, valid_next;
    logic               busy_q, busy_next;
    logic               done_q, done_next;
    logic               transfer;
    logic [7:0]         status_byte;

    function automatic logic [7:0] result_byte(input logic [P_WIDTH-1:0] r,
                                               input logic [IDX_W-1:0]   i);
        logic [P_WIDTH-1:0] shifted;
        shifted = r >> {i, 3'b000};
        return shifted[7:0];
    endfunction

    assign transfer    = valid_q && bus.ready;
    assign status_byte = {3'b000, status_q};

    // Every output is computed one cycle ahead here and registered below, so
    // valid never depends combinationally on ready.
    always_comb begin
        state_next    = state;
        result_next   = result_q;
        status_next   = status_q;
        index_next    = index;
        checksum_next = checksum;
        byte_next     = byte_q;
        valid_next    = valid_q;
        busy_next     = busy_q;
        done_next     = 1'b0;

        unique case (state)
            IDLE: begin
                if (bus.start) begin
                    result_next   = bus.result;
                    status_next   = bus.status;
                    checksum_next = P_HEADER;
                    byte_next     = P_HEADER;
                    valid_next    = 1'b1;
                    busy_next     = 1'b1;
                    state_next    = HEADER;
                end
            end
            HEADER: begin
                if (transfer) begin
                    index_next = LAST_IDX;
                    byte_next  = result_byte(result_q, LAST_IDX);
                    state_next = DATA;
                end
            end
            DATA: begin
                if (transfer) begin
                    checksum_next = checksum ^ byte_q;
                    if (index == '0) begin
                        byte_next  = status_byte;
                        state_next = STATUS;
                    end else begin
                        index_next = index - 1'b1;
                        byte_next  = result_byte(result_q, index - 1'b1);
                    end
                end
            end
            STATUS: begin
                if (transfer) begin
                    checksum_next = checksum ^ status_byte;
                    byte_next     = checksum ^ status_byte;
                    state_next    = CHECKSUM;
                end
            end
            CHECKSUM: begin
                if (transfer) begin
                    valid_next = 1'b0;
                    busy_next  = 1'b0;
                    done_next  = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            result_q <= '0;
            status_q <= '0;
            index    <= '0;
            checksum <= '0;
            byte_q   <= '0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state    <= state_next;
            result_q <= result_next;
            status_q <= status_next;
            index    <= index_next;
            checksum <= checksum_next;
            byte_q   <= byte_next;
            valid_q  <= valid_next;
            busy_q   <= busy_next;
            done_q   <= done_next;
        end
    end

    assign bus.stream_byte = byte_q;
    assign bus.valid       = valid_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
endmodule

// File: tb/tb_alu_result_streamer.sv
// Bench for alu_result_streamer: a frame-queue model checks the 16-bit instance
// every cycle, and literal byte sequences pin both the model and the 32-bit instance.
module tb_alu_result_streamer;
    localparam logic [7:0] HDR = 8'hA5;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    alu_result_streamer_if #(.P_WIDTH(16)) bus16 ();
    alu_result_streamer_if #(.P_WIDTH(32)) bus32 ();

    alu_result_streamer #(.P_WIDTH(16), .P_HEADER(HDR)) dut16 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus16)
    );

    alu_result_streamer #(.P_WIDTH(32), .P_HEADER(HDR)) dut32 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus32)
    );

    int         checks = 0;
    int         fails  = 0;
    logic [7:0] exp_q[$];
    bit         exp_done = 1'b0;
    logic [7:0] rx16[$];
    logic [7:0] rx32[$];
    int         done16 = 0;
    int         busy16 = 0;
    int         done32 = 0;

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // A frame is simply the byte list the link must carry, checksum folded in.
    function automatic void build_frame(input logic [15:0] r, input logic [4:0] s);
        logic [7:0] frame[4];
        logic [7:0] cs;
        frame[0] = HDR;
        frame[1] = r[15:8];
        frame[2] = r[7:0];
        frame[3] = {3'b000, s};
        cs = 8'h00;
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(frame[i]);
            cs = cs ^ frame[i];
        end
        exp_q.push_back(cs);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_q.delete();
            exp_done = 1'b0;
        end else if (exp_q.size() == 0) begin
            exp_done = 1'b0;
            if (bus16.start) build_frame(bus16.result, bus16.status);
        end else if (bus16.ready) begin
            void'(exp_q.pop_front());
            exp_done = (exp_q.size() == 0);
        end else begin
            exp_done = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            check_output("valid16", 32'(bus16.valid), 32'(exp_q.size() != 0));
            check_output("busy16", 32'(bus16.busy), 32'(exp_q.size() != 0));
            check_output("done16", 32'(bus16.done), 32'(exp_done));
            if (exp_q.size() != 0) check_output("byte16", 32'(bus16.stream_byte), 32'(exp_q[0]));
            if (bus16.valid && bus16.ready) rx16.push_back(bus16.stream_byte);
            if (bus16.done) done16++;
            if (bus16.busy) busy16++;
            if (bus32.valid && bus32.ready) rx32.push_back(bus32.stream_byte);
            if (bus32.done) done32++;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic apply_stimulus(input logic [15:0] r, input logic [4:0] s,
                                  input logic rdy, input logic st);
        bus16.result = r;
        bus16.status = s;
        bus16.ready  = rdy;
        bus16.start  = st;
    endtask

    task automatic clear_log();
        rx16.delete();
        done16 = 0;
        busy16 = 0;
    endtask

    task automatic check_frame16(input string name, input int base);
        logic [7:0] lit[5];
        lit = '{8'hA5, 8'h12, 8'h34, 8'h03, 8'h80};
        for (int i = 0; i < 5; i++)
            check_output($sformatf("%s byte%0d", name, i),
                         32'((base + i < rx16.size()) ? rx16[base + i] : 8'hxx), 32'(lit[i]));
    endtask

    initial begin
        logic [13:0] pat;
        logic [7:0]  lit32[7];
        pat   = 14'b11110101101001;
        lit32 = '{8'hA5, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h00, 8'h87};
        apply_stimulus(16'h0000, 5'd0, 1'b0, 1'b0);
        bus32.start  = 1'b0;
        bus32.result = '0;
        bus32.status = '0;
        bus32.ready  = 1'b0;

        #12;
        check_output("reset valid16", 32'(bus16.valid), 32'd0);
        check_output("reset busy16", 32'(bus16.busy), 32'd0);
        check_output("reset done16", 32'(bus16.done), 32'd0);
        check_output("reset byte16", 32'(bus16.stream_byte), 32'd0);
        check_output("reset valid32", 32'(bus32.valid), 32'd0);
        check_output("reset busy32", 32'(bus32.busy), 32'd0);
        rst_n = 1'b1;
        tick(1);

        // Free-flowing sink: five back-to-back bytes, one done pulse.
        clear_log();
        apply_stimulus(16'h1234, 5'b00011, 1'b1, 1'b1);
        tick(1);
        bus16.start = 1'b0;
        tick(8);
        check_output("t1 count", 32'(rx16.size()), 32'd5);
        check_frame16("t1", 0);
        check_output("t1 done pulses", 32'(done16), 32'd1);
        check_output("t1 busy cycles", 32'(busy16), 32'd5);

        // Stalling sink.
        clear_log();
        apply_stimulus(16'h1234, 5'b00011, 1'b1, 1'b1);
        tick(1);
        bus16.start = 1'b0;
        for (int i = 0; i < 14; i++) begin
            bus16.ready = pat[i];
            tick(1);
        end
        bus16.ready = 1'b1;
        tick(4);
        check_output("t2 count", 32'(rx16.size()), 32'd5);
        check_frame16("t2", 0);
        check_output("t2 done pulses", 32'(done16), 32'd1);

        // Inputs changing and a second start while the frame is in flight.
        clear_log();
        apply_stimulus(16'h1234, 5'b00011, 1'b1, 1'b1);
        tick(1);
        apply_stimulus(16'hFFFF, 5'b00011, 1'b1, 1'b0);
        tick(2);
        bus16.start = 1'b1;
        tick(1);
        bus16.start = 1'b0;
        tick(8);
        check_output("t3 count", 32'(rx16.size()), 32'd5);
        check_frame16("t3", 0);
        check_output("t3 done pulses", 32'(done16), 32'd1);

        bus32.result = 32'hDEADBEEF;
        bus32.status = 5'd0;
        bus32.ready  = 1'b1;
        bus32.start  = 1'b1;
        tick(1);
        bus32.start = 1'b0;
        tick(10);
        check_output("t4 count", 32'(rx32.size()), 32'd7);
        for (int i = 0; i < 7; i++)
            check_output($sformatf("t4 byte%0d", i),
                         32'((i < rx32.size()) ? rx32[i] : 8'hxx), 32'(lit32[i]));
        check_output("t4 done pulses", 32'(done32), 32'd1);

        // Asynchronous abort while the 0x34 data byte is stalled.
        clear_log();
        apply_stimulus(16'h1234, 5'b00011, 1'b0, 1'b1);
        tick(1);
        bus16.start = 1'b0;
        bus16.ready = 1'b1;
        tick(2);
        bus16.ready = 1'b0;
        tick(1);
        check_output("t5 pending byte", 32'(bus16.stream_byte), 32'h34);
        #1 rst_n = 1'b0;
        #1;
        check_output("t5 async valid", 32'(bus16.valid), 32'd0);
        check_output("t5 async busy", 32'(bus16.busy), 32'd0);
        tick(1);
        rst_n = 1'b1;
        tick(3);
        check_output("t5 no done", 32'(done16), 32'd0);
        clear_log();
        apply_stimulus(16'h1234, 5'b00011, 1'b1, 1'b1);
        tick(1);
        bus16.start = 1'b0;
        tick(8);
        check_output("t5 count", 32'(rx16.size()), 32'd5);
        check_frame16("t5", 0);
        check_output("t5 done pulses", 32'(done16), 32'd1);

        // Held start relaunches every six cycles.
        clear_log();
        apply_stimulus(16'h1234, 5'b00011, 1'b1, 1'b1);
        tick(18);
        bus16.start = 1'b0;
        tick(8);
        check_output("t6 count", 32'(rx16.size()), 32'd15);
        check_frame16("t6 f0", 0);
        check_frame16("t6 f1", 5);
        check_frame16("t6 f2", 10);
        check_output("t6 done pulses", 32'(done16), 32'd3);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
